// File: rtl/axi_sub_wr_arb.sv
// ---------------------------------------------------------------------------
// axi_sub_wr_arb
//
// Purpose: arbitrates N write-burst requesters onto one downstream write
// port. A grant is taken in IDLE, held for the whole burst in OWN (no
// interleaving between requesters), and released once the owner's last beat
// is accepted.
//
// Configuration macro: AXI_SUB_WR_ARB_RR_EN
//   defined   -> round-robin arbitration (search starts at a rotating pointer)
//   undefined -> fixed priority, lowest requester index wins
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_dv[N]            per-requester beat valid
//   req_addr/user/id     per-requester beat fields (packed, N slices each)
//   req_wdata/wstrb      per-requester write data and byte strobes
//   req_last[N]          per-requester final beat of burst
//   req_hld[N]           stall back to each requester
//   req_err[N]           error back to each requester
//   dv..last             downstream beat (owner's beat while OWN, else 0)
//   hld, err             downstream stall and error
//   busy                 a grant is held (FSM in OWN)
//   owner                index of the granted requester
// ---------------------------------------------------------------------------
module axi_sub_wr_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int UW = 32,
  parameter int IW = 1,
  parameter int N  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req_dv,
  input  logic [N*AW-1:0]       req_addr,
  input  logic [N*UW-1:0]       req_user,
  input  logic [N*IW-1:0]       req_id,
  input  logic [N*DW-1:0]       req_wdata,
  input  logic [N*(DW/8)-1:0]   req_wstrb,
  input  logic [N-1:0]          req_last,
  output logic [N-1:0]          req_hld,
  output logic [N-1:0]          req_err,
  output logic                  dv,
  output logic [AW-1:0]         addr,
  output logic [UW-1:0]         user,
  output logic [IW-1:0]         id,
  output logic [DW-1:0]         wdata,
  output logic [(DW/8)-1:0]     wstrb,
  output logic                  last,
  input  logic                  hld,
  input  logic                  err,
  output logic                  busy,
  output logic [$clog2(N)-1:0]  owner
);

  localparam int BC = DW / 8;
  localparam int OW = $clog2(N);
  localparam logic [OW-1:0] LAST_IDX = OW'(N - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] winner;
  logic          burst_done;

  // Unpack the per-requester buses so the owner mux is a plain array index.
  logic [AW-1:0] addr_a  [N];
  logic [UW-1:0] user_a  [N];
  logic [IW-1:0] id_a    [N];
  logic [DW-1:0] wdata_a [N];
  logic [BC-1:0] wstrb_a [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign addr_a[gi]  = req_addr[gi*AW +: AW];
    assign user_a[gi]  = req_user[gi*UW +: UW];
    assign id_a[gi]    = req_id[gi*IW +: IW];
    assign wdata_a[gi] = req_wdata[gi*DW +: DW];
    assign wstrb_a[gi] = req_wstrb[gi*BC +: BC];
  end

  // A burst ends only on an accepted last beat; a stalled last beat keeps
  // the grant.
  assign burst_done = (state_q == S_OWN) && req_dv[owner_q] &&
                      req_last[owner_q] && !hld;

`ifdef AXI_SUB_WR_ARB_RR_EN
  logic [OW-1:0] ptr_q, ptr_d;

  // Round-robin: first requesting index at or after the pointer, wrapping.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_dv[idx]) begin
        winner = OW'(idx);
        found  = 1'b1;
      end
    end
  end

  // Pointer moves just past the owner when its burst completes.
  always_comb begin
    ptr_d = ptr_q;
    if (burst_done) begin
      ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Fixed priority: scan downwards so the lowest requesting index is last
  // to be written and therefore wins.
  always_comb begin
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_dv[k]) winner = OW'(k);
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      S_IDLE: begin
        if (|req_dv) begin
          owner_d = winner;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (burst_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Output mux: zero-latency forwarding of the owner's beat while OWN;
  // everything downstream is quiet and every requester stalled otherwise.
  always_comb begin
    dv      = 1'b0;
    addr    = '0;
    user    = '0;
    id      = '0;
    wdata   = '0;
    wstrb   = '0;
    last    = 1'b0;
    req_hld = '1;
    req_err = '0;
    if (state_q == S_OWN) begin
      dv               = req_dv[owner_q];
      addr             = addr_a[owner_q];
      user             = user_a[owner_q];
      id               = id_a[owner_q];
      wdata            = wdata_a[owner_q];
      wstrb            = wstrb_a[owner_q];
      last             = req_last[owner_q];
      req_hld[owner_q] = hld;
      req_err[owner_q] = err;
    end
  end

  assign busy  = (state_q == S_OWN);
  assign owner = owner_q;

endmodule

// File: tb/tb_axi_sub_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_axi_sub_wr_arb
//
// Directed scenarios followed by a randomized phase. Expected outputs come
// from a burst-level grant model (who holds the grant, where the round-robin
// search starts) evaluated with plain integer arithmetic every cycle.
// Honors AXI_SUB_WR_ARB_RR_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_axi_sub_wr_arb;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int UW = 8;
  localparam int IW = 2;
  localparam int N  = 3;
  localparam int BC = DW / 8;
  localparam int OW = $clog2(N);

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_dv;
  logic [N*AW-1:0]   req_addr;
  logic [N*UW-1:0]   req_user;
  logic [N*IW-1:0]   req_id;
  logic [N*DW-1:0]   req_wdata;
  logic [N*BC-1:0]   req_wstrb;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_hld;
  logic [N-1:0]      req_err;
  logic              dv;
  logic [AW-1:0]     addr;
  logic [UW-1:0]     user;
  logic [IW-1:0]     id;
  logic [DW-1:0]     wdata;
  logic [BC-1:0]     wstrb;
  logic              last;
  logic              hld;
  logic              err;
  logic              busy;
  logic [OW-1:0]     owner;

  axi_sub_wr_arb #(.AW(AW), .DW(DW), .UW(UW), .IW(IW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_dv(req_dv), .req_addr(req_addr), .req_user(req_user),
    .req_id(req_id), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_last(req_last), .req_hld(req_hld), .req_err(req_err),
    .dv(dv), .addr(addr), .user(user), .id(id), .wdata(wdata),
    .wstrb(wstrb), .last(last), .hld(hld), .err(err),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Grant model: is a grant held, by whom, and where the next search starts.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d: observed=%0h expected=%0h", tag, cycle, got, exp);
    end
  endtask

  function automatic int pick();
    int w;
    w = -1;
`ifdef AXI_SUB_WR_ARB_RR_EN
    for (int k = 0; k < N; k++)
      if (w < 0 && req_dv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`else
    for (int k = 0; k < N; k++)
      if (w < 0 && req_dv[k]) w = k;
`endif
    return w;
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_hld, e_err;
    int o;
    o     = m_owner;
    e_hld = '1;
    e_err = '0;
    if (m_busy) begin
      e_hld[o] = hld;
      e_err[o] = err;
    end
    chk("busy",  busy,  m_busy);
    chk("owner", owner, m_owner);
    chk("dv",    dv,    m_busy ? req_dv[o] : 1'b0);
    chk("addr",  addr,  m_busy ? req_addr[o*AW +: AW] : '0);
    chk("user",  user,  m_busy ? req_user[o*UW +: UW] : '0);
    chk("id",    id,    m_busy ? req_id[o*IW +: IW] : '0);
    chk("wdata", wdata, m_busy ? req_wdata[o*DW +: DW] : '0);
    chk("wstrb", wstrb, m_busy ? req_wstrb[o*BC +: BC] : '0);
    chk("last",  last,  m_busy ? req_last[o] : 1'b0);
    chk("req_hld", req_hld, e_hld);
    chk("req_err", req_err, e_err);
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (|req_dv) begin
        m_owner = pick();
        m_busy  = 1'b1;
      end
    end else if (req_dv[m_owner] && req_last[m_owner] && !hld) begin
      m_busy = 1'b0;
`ifdef AXI_SUB_WR_ARB_RR_EN
      m_ptr = (m_owner + 1) % N;
`endif
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick();
    #1;
    if (!rst_n) model_reset();
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cycle++;
  endtask

  task automatic rand_data(int r);
    req_addr[r*AW +: AW]  = AW'($urandom);
    req_user[r*UW +: UW]  = UW'($urandom);
    req_id[r*IW +: IW]    = IW'($urandom);
    req_wdata[r*DW +: DW] = DW'($urandom);
    req_wstrb[r*BC +: BC] = BC'($urandom);
  endtask

  task automatic set_req(int r, bit v, bit l);
    req_dv[r]   = v;
    req_last[r] = l;
    rand_data(r);
  endtask

  task automatic clear_all();
    req_dv   = '0;
    req_last = '0;
    hld      = 1'b0;
    err      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int grants[$];
  int gcyc[$];

  initial begin
    rst_n = 1'b0;
    clear_all();
    for (int r = 0; r < N; r++) rand_data(r);
    @(negedge clk);

    // Reset state.
    do_reset();
    tick();

    // Four-beat burst from requester 0 with no stalls.
    set_req(0, 1, 0); tick();              // IDLE, arbitration
    for (int b = 1; b <= 4; b++) begin
      set_req(0, 1, b == 4);
      tick();
      chk("burst_busy", busy, b < 4);      // stays OWN until the last beat
    end
    clear_all(); tick();
    $display("burst4 done cycle=%0d", cycle);

    // Both requesters hammering single beats.
    do_reset();
    grants.delete(); gcyc.delete();
    for (int c = 0; c < 8; c++) begin
      set_req(0, 1, 1);
      set_req(1, 1, 1);
      tick();
      if (busy) begin
        grants.push_back(int'(owner));
        gcyc.push_back(cycle);
      end
    end
    chk("grant_count", grants.size(), 4);
    for (int g = 0; g < grants.size(); g++) begin
`ifdef AXI_SUB_WR_ARB_RR_EN
      chk("grant_seq", grants[g], g % 2);
`else
      chk("grant_seq", grants[g], 0);
`endif
      if (g > 0) chk("grant_gap", gcyc[g] - gcyc[g-1], 2);
    end
    clear_all(); tick();
    $display("contention done grants=%0d", grants.size());

    // Requester 1, three beats, stall on beat 2, error on beat 3.
    set_req(1, 1, 0); tick();
    set_req(1, 1, 0); tick();
    set_req(1, 1, 0); hld = 1'b1;
    tick(); tick(); tick();                // beat 2 held stable
    hld = 1'b0; tick();
    set_req(1, 1, 1); err = 1'b1; tick();
    chk("err_burst_end", busy, 1'b0);
    clear_all(); tick();
    $display("stall/err done cycle=%0d", cycle);

    // Owner 0 pauses mid-burst while requester 1 waits.
    set_req(0, 1, 0); tick();
    set_req(0, 1, 0); tick();
    req_dv[0] = 1'b0; set_req(1, 1, 1);
    tick(); tick();
    chk("gap_owner", owner, 0);
    set_req(0, 1, 0); tick();
    set_req(0, 1, 1); tick();
    req_dv[0] = 1'b0; tick();              // IDLE, requester 1 arbitrates
    chk("after_gap_owner", owner, 1);
    tick();
    clear_all(); tick();
    $display("gap done cycle=%0d", cycle);

    // Reset lands on beat 2 of a four-beat burst.
    set_req(0, 1, 0); tick();
    set_req(0, 1, 0); tick();
    set_req(0, 1, 0); set_req(1, 1, 0); rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    set_req(0, 1, 1); set_req(1, 1, 1); tick();
    chk("post_reset_owner", owner, 0);
    chk("post_reset_busy", busy, 1'b1);
    clear_all(); tick(); tick();
    $display("mid-burst reset done cycle=%0d", cycle);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      for (int r = 0; r < N; r++) set_req(r, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
      hld   = $urandom_range(0, 3) == 0;
      err   = $urandom_range(0, 4) == 0;
      rst_n = $urandom_range(0, 199) != 0;
      tick();
    end
    rst_n = 1'b1;
    $display("random phase done cycle=%0d", cycle);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
